// File: rtl/unidade_controle_exp3.sv
// unidade_controle_exp3: control FSM for the search/load counter experiment
//
// Ports:
//   clock_i      rising-edge system clock
//   reset_i      asynchronous active-high reset, forces INICIAL immediately
//   iniciar_i    level-sensitive start request
//   modo_i       0 = search (count up until count == chaves), 1 = load chaves and count to 15
//   pausa_i      freezes counting while high
//   igual_i      datapath equality flag (count == chaves)
//   fim_i        datapath ripple carry (count == 15 with count enable)
//   zera_o       datapath clear strobe
//   carrega_o    datapath load strobe
//   conta_o      datapath count enable
//   pronto_o     operation finished (ACHOU or FIM)
//   erro_o       operation failed (ERRO)
//   db_modo_o    latched mode
//   db_estado_o  state code for the seven-segment display
module unidade_controle_exp3 #(
    parameter int TIMEOUT = 255
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       iniciar_i,
    input  logic       modo_i,
    input  logic       pausa_i,
    input  logic       igual_i,
    input  logic       fim_i,
    output logic       zera_o,
    output logic       carrega_o,
    output logic       conta_o,
    output logic       pronto_o,
    output logic       erro_o,
    output logic       db_modo_o,
    output logic [3:0] db_estado_o
);
    localparam logic [3:0] INICIAL = 4'h0;
    localparam logic [3:0] PREPARA = 4'h1;
    localparam logic [3:0] CARREGA = 4'h2;
    localparam logic [3:0] CONTA   = 4'h3;
    localparam logic [3:0] PAUSA   = 4'h4;
    localparam logic [3:0] ACHOU   = 4'h5;
    localparam logic [3:0] ERRO    = 4'hE;
    localparam logic [3:0] FIM     = 4'hF;
    localparam logic [7:0] ESPERA_MAX = 8'(TIMEOUT - 1);

    logic [3:0] estado_q, estado_d;
    logic       modo_q, modo_d;
    logic [7:0] espera_q, espera_d;
    logic       achou;
    logic [3:0] partida;

    // Search mode stops on a match; load mode ignores the comparator.
    assign achou   = !modo_q && igual_i;
    assign partida = modo_i ? CARREGA : PREPARA;

    always_comb begin
        estado_d = estado_q;
        modo_d   = modo_q;
        case (estado_q)
            INICIAL, ACHOU, FIM, ERRO: begin
                estado_d = iniciar_i ? partida : estado_q;
                modo_d   = iniciar_i ? modo_i : modo_q;
            end
            PREPARA, CARREGA: estado_d = CONTA;
            CONTA:   estado_d = pausa_i ? PAUSA :
                                achou   ? ACHOU :
                                fim_i   ? (modo_q ? FIM : ERRO) : CONTA;
            PAUSA:   estado_d = !pausa_i ? CONTA :
                                (espera_q == ESPERA_MAX) ? ERRO : PAUSA;
            default: estado_d = INICIAL;
        endcase
    end

    // Wait counter lives only in PAUSA: zero everywhere else, saturating inside.
    always_comb begin
        espera_d = (estado_q != PAUSA) ? 8'd0 :
                   (&espera_q)         ? espera_q : espera_q + 8'd1;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q <= INICIAL;
            modo_q   <= 1'b0;
            espera_q <= 8'd0;
        end else begin
            estado_q <= estado_d;
            modo_q   <= modo_d;
            espera_q <= espera_d;
        end
    end

    assign zera_o      = (estado_q == PREPARA);
    assign carrega_o   = (estado_q == CARREGA);
    assign conta_o     = (estado_q == CONTA) && !pausa_i && !achou;
    assign pronto_o    = (estado_q == ACHOU) || (estado_q == FIM);
    assign erro_o      = (estado_q == ERRO);
    assign db_modo_o   = modo_q;
    assign db_estado_o = estado_q;
endmodule

// File: tb/tb_unidade_controle_exp3.sv
// tb_unidade_controle_exp3: directed vectors plus datapath-model sequences
module tb_unidade_controle_exp3;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0, modo = 1'b0, pausa = 1'b0;
    logic       tb_igual = 1'b0, tb_fim = 1'b0, use_model = 1'b0;
    logic [3:0] chaves = 4'd0, cnt;
    logic       igual, fim;
    logic       zera, carrega, conta, pronto, erro, db_modo;
    logic [3:0] db_estado;
    int         errors = 0, checks = 0;
    int         n, fim_at, g;

    always #5 clock = ~clock;

    unidade_controle_exp3 #(.TIMEOUT(8)) dut (
        .clock_i(clock), .reset_i(reset), .iniciar_i(iniciar), .modo_i(modo),
        .pausa_i(pausa), .igual_i(igual), .fim_i(fim), .zera_o(zera),
        .carrega_o(carrega), .conta_o(conta), .pronto_o(pronto), .erro_o(erro),
        .db_modo_o(db_modo), .db_estado_o(db_estado)
    );

    always @(posedge clock) begin
        if (zera) cnt <= 4'd0;
        else if (carrega) cnt <= chaves;
        else if (conta) cnt <= cnt + 4'd1;
    end

    assign igual = use_model ? (cnt == chaves) : tb_igual;
    assign fim   = use_model ? (cnt == 4'hF && conta) : tb_fim;

    typedef struct packed {
        logic       rst, ini, modo, pausa, igual, fim;
        logic [9:0] exp;
    } vec_t;
    vec_t v [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic m, input logic [3:0] k);
        modo = m;
        chaves = k;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
    endtask

    task automatic run();
        n = 0;
        fim_at = 0;
        g = 0;
        while (db_estado == 4'h3 && g < 40) begin
            if (conta) n++;
            if (fim) fim_at = n;
            step();
            g++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        // {rst,ini,modo,pausa,igual,fim}, {estado, zera,carrega,conta,pronto,erro,db_modo}
        v[0]  = {6'b100000, 10'b0000_000000};
        v[1]  = {6'b111000, 10'b0000_000000};
        v[2]  = {6'b000000, 10'b0000_000000};
        v[3]  = {6'b010000, 10'b0000_000000};
        v[4]  = {6'b000000, 10'b0001_100000};
        v[5]  = {6'b000000, 10'b0011_001000};
        v[6]  = {6'b000010, 10'b0011_000000};
        v[7]  = {6'b000000, 10'b0101_000100};
        v[8]  = {6'b011000, 10'b0101_000100};
        v[9]  = {6'b000000, 10'b0010_010001};
        v[10] = {6'b000010, 10'b0011_001001};
        v[11] = {6'b000001, 10'b0011_001001};
        v[12] = {6'b000000, 10'b1111_000101};
        v[13] = {6'b010000, 10'b1111_000101};
        v[14] = {6'b000000, 10'b0001_100000};
        v[15] = {6'b000111, 10'b0011_000000};
        v[16] = {6'b000000, 10'b0100_000000};
        v[17] = {6'b000001, 10'b0011_001000};
        v[18] = {6'b000000, 10'b1110_000010};
        v[19] = {6'b000000, 10'b1110_000010};
        v[20] = {6'b100000, 10'b0000_000000};
        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            reset = v[i].rst; iniciar = v[i].ini; modo = v[i].modo;
            pausa = v[i].pausa; tb_igual = v[i].igual; tb_fim = v[i].fim;
            #1;
            chk($sformatf("vec%0d", i), {22'd0, db_estado, zera, carrega, conta, pronto, erro, db_modo}, {22'd0, v[i].exp});
        end

        // search for 5
        @(negedge clock);
        reset = 1'b0; use_model = 1'b1; iniciar = 1'b0; pausa = 1'b0;
        modo = 1'b0; chaves = 4'd5; iniciar = 1'b1;
        step();
        chk("A_prepara", db_estado, 1);
        chk("A_zera", zera, 1);
        iniciar = 1'b0;
        step();
        chk("A_conta_state", db_estado, 3);
        run();
        chk("A_conta_cycles", n, 5);
        chk("A_state", db_estado, 5);
        chk("A_pronto", pronto, 1);
        step(); step();
        chk("A_count_frozen", cnt, 5);

        // load 12, count to 15 and wrap
        modo = 1'b1; chaves = 4'd12; iniciar = 1'b1;
        step();
        chk("B_carrega_state", db_estado, 2);
        chk("B_carrega", carrega, 1);
        iniciar = 1'b0;
        step();
        chk("B_loaded", cnt, 12);
        run();
        chk("B_conta_cycles", n, 4);
        chk("B_fim_at", fim_at, 4);
        chk("B_state", db_estado, 4'hF);
        chk("B_pronto", pronto, 1);
        chk("B_count_wrap", cnt, 0);

        // search target moved below the count: no match, ends at 15
        start(1'b0, 4'd5);
        g = 0;
        while (cnt != 4'd4 && g < 20) begin step(); g++; end
        chaves = 4'd3;
        run();
        chk("C_conta_cycles", n, 12);
        chk("C_fim_at", fim_at, 12);
        chk("C_state", db_estado, 4'hE);
        chk("C_erro", erro, 1);

        // pause below the timeout, then resume
        start(1'b0, 4'd9);
        g = 0;
        while (cnt != 4'd4 && g < 20) begin step(); g++; end
        pausa = 1'b1;
        #1;
        chk("D_conta_gated", conta, 0);
        step();
        chk("D_pausa_state", db_estado, 4);
        repeat (5) step();
        chk("D_still_paused", db_estado, 4);
        chk("D_count_held", cnt, 4);
        chk("D_conta_off", conta, 0);
        pausa = 1'b0;
        step();
        chk("D_resume", db_estado, 3);
        run();
        chk("D_state", db_estado, 5);
        chk("D_count", cnt, 9);

        // pause timeout: ERRO after the 8th PAUSA cycle
        start(1'b0, 4'd9);
        pausa = 1'b1;
        repeat (8) step();
        chk("E_8th_cycle_paused", db_estado, 4);
        step();
        chk("E_timeout_state", db_estado, 4'hE);
        chk("E_erro", erro, 1);
        pausa = 1'b0;

        // asynchronous reset mid-count
        start(1'b1, 4'd2);
        step();
        chk("F_counting", conta, 1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("F_async_state", db_estado, 0);
        chk("F_async_conta", conta, 0);
        chk("F_async_modo", db_modo, 0);
        @(negedge clock);
        reset = 1'b0;
        step(); step();
        chk("F_idle_after_release", db_estado, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
